// File: rtl/io_pio_input.sv
// Debounced parallel input port with per-pin edge capture and a
// level interrupt, behind a small word-addressed register file.
module io_pio_input #(
  parameter int WIDTH    = 8,
  parameter int DEBOUNCE = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [7:0]       addr,
  input  logic [31:0]      datain,
  input  logic             we,
  output logic [31:0]      dataout,
  input  logic [WIDTH-1:0] pio,
  output logic             irq
);

  localparam logic [15:0] CntMax = 16'(DEBOUNCE - 1);

  logic [WIDTH-1:0] sync1_q, sync2_q;
  logic [WIDTH-1:0] stable_q, stable_d;
  logic [15:0]      cnt_q [WIDTH];
  logic [15:0]      cnt_d [WIDTH];
  logic [WIDTH-1:0] edge_q, edge_d;
  logic [WIDTH-1:0] mask_q, mask_d;
  logic [WIDTH-1:0] rise_q, rise_d;
  logic [WIDTH-1:0] fall_q, fall_d;

  logic [5:0]       word;
  logic [WIDTH-1:0] wdata;
  logic [WIDTH-1:0] set;
  logic [WIDTH-1:0] clr;
  logic             unused_bits;

  assign word        = addr[7:2];
  assign wdata       = datain[WIDTH-1:0];
  assign unused_bits = ^{addr[1:0], datain};

  // A pin flips only after DEBOUNCE consecutive edges disagreeing.
  always_comb begin
    stable_d = stable_q;
    for (int i = 0; i < WIDTH; i++) begin
      cnt_d[i] = cnt_q[i];
      if (sync2_q[i] == stable_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CntMax) begin
        stable_d[i] = sync2_q[i];
        cnt_d[i]    = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + 16'd1;
      end
    end
  end

  always_comb begin
    set    = (rise_q & stable_d & ~stable_q)
           | (fall_q & ~stable_d & stable_q);
    clr    = '0;
    mask_d = mask_q;
    rise_d = rise_q;
    fall_d = fall_q;
    if (we) begin
      unique case (word)
        6'd1:    clr    = wdata;
        6'd2:    mask_d = wdata;
        6'd3:    rise_d = wdata;
        6'd4:    fall_d = wdata;
        default: ;
      endcase
    end
    // A new event beats a same-cycle clear.
    edge_d = (edge_q & ~clr) | set;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q  <= '0;
      sync2_q  <= '0;
      stable_q <= '0;
      edge_q   <= '0;
      mask_q   <= '0;
      rise_q   <= '0;
      fall_q   <= '0;
      for (int i = 0; i < WIDTH; i++) cnt_q[i] <= '0;
    end else begin
      sync1_q  <= pio;
      sync2_q  <= sync1_q;
      stable_q <= stable_d;
      edge_q   <= edge_d;
      mask_q   <= mask_d;
      rise_q   <= rise_d;
      fall_q   <= fall_d;
      for (int i = 0; i < WIDTH; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  always_comb begin
    dataout = '0;
    unique case (word)
      6'd0:    dataout = 32'(stable_q);
      6'd1:    dataout = 32'(edge_q);
      6'd2:    dataout = 32'(mask_q);
      6'd3:    dataout = 32'(rise_q);
      6'd4:    dataout = 32'(fall_q);
      default: dataout = '0;
    endcase
  end

  assign irq = |(edge_q & mask_q);

endmodule

// File: tb/tb_io_pio_input.sv
// Randomized self-checking bench for io_pio_input against a
// sliding-window behavioural model of debounce and edge capture.
`timescale 1ns/1ps
module tb_io_pio_input;

  localparam int W = 8;
  localparam int D = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  addr = '0;
  logic [31:0] datain = '0;
  logic        we = 1'b0;
  logic [31:0] dataout;
  logic [W-1:0] pio = '0;
  logic        irq;

  int n_cmp = 0;
  int n_bad = 0;

  io_pio_input #(.WIDTH(W), .DEBOUNCE(D)) dut (
    .clk(clk), .reset(reset), .addr(addr), .datain(datain),
    .we(we), .dataout(dataout), .pio(pio), .irq(irq)
  );

  always #5 clk = ~clk;

  logic [W-1:0] hist [$];
  logic [W-1:0] m_stable, m_edge, m_mask, m_rise, m_fall;

  task automatic model_reset();
    hist.delete();
    m_stable = '0; m_edge = '0; m_mask = '0;
    m_rise = '0; m_fall = '0;
  endtask

  task automatic model_step();
    logic [W-1:0] ns, set, clr;
    int n, idx;
    bit all;
    if (reset) begin
      model_reset();
      return;
    end
    hist.push_back(pio);
    if (hist.size() > D + 8) void'(hist.pop_front());
    n = hist.size();
    ns = m_stable;
    for (int i = 0; i < W; i++) begin
      all = 1'b1;
      for (int k = 0; k < D; k++) begin
        idx = n - 3 - k;
        if (((idx >= 0) ? hist[idx][i] : 1'b0) == m_stable[i]) all = 1'b0;
      end
      if (all) ns[i] = ~m_stable[i];
    end
    set = (m_rise & ns & ~m_stable) | (m_fall & ~ns & m_stable);
    clr = '0;
    if (we) begin
      case (addr[7:2])
        6'd1: clr = datain[W-1:0];
        6'd2: m_mask = datain[W-1:0];
        6'd3: m_rise = datain[W-1:0];
        6'd4: m_fall = datain[W-1:0];
        default: ;
      endcase
    end
    m_edge = (m_edge & ~clr) | set;
    m_stable = ns;
  endtask

  function automatic logic [31:0] exp_word(input int w);
    case (w)
      0: return 32'(m_stable);
      1: return 32'(m_edge);
      2: return 32'(m_mask);
      3: return 32'(m_rise);
      4: return 32'(m_fall);
      default: return 32'h0;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    we = 1'b0;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic wr(input int w, input logic [31:0] d);
    addr = {6'(w), 2'($urandom_range(0, 3))};
    datain = d;
    we = 1'b1;
    tick();
  endtask

  task automatic rd(input int w, output logic [31:0] d);
    addr = {6'(w), 2'($urandom_range(0, 3))};
    #1;
    d = dataout;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    ticks(2);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] d;
    reset = 1'b1;
    pio = 8'hFF;
    ticks(3);
    for (int w = 0; w < 6; w++) begin
      rd(w, d);
      n_cmp++;
      if (d !== 32'h0) begin
        n_bad++;
        $display("FAIL reset_read w%0d got %h want 0", w, d);
      end
    end
    n_cmp++;
    if (irq !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_irq got %b want 0", irq);
    end
    pio = '0;
    reset = 1'b0;
    ticks(8);
  endtask

  task automatic test_glitch();
    logic [31:0] d, e;
    do_reset();
    wr(3, 32'hFF);
    wr(4, 32'hFF);
    pio = 8'h01;
    ticks(3);
    pio = 8'h00;
    for (int c = 0; c < 8; c++) begin
      tick();
      rd(0, d);
      rd(1, e);
      n_cmp++;
      if (d !== 32'h0 || e !== 32'h0) begin
        n_bad++;
        $display("FAIL glitch c%0d data %h edge %h want 0/0", c, d, e);
      end
    end
  endtask

  task automatic test_debounce();
    logic [31:0] d, exp;
    do_reset();
    ticks(3);
    pio = 8'h01;
    for (int e = 0; e <= 6; e++) begin
      tick();
      rd(0, d);
      exp = (e >= 5) ? 32'h1 : 32'h0;
      n_cmp++;
      if (d !== exp) begin
        n_bad++;
        $display("FAIL debounce k+%0d got %h want %h", e, d, exp);
      end
    end
  endtask

  task automatic test_rise_irq();
    logic [31:0] d;
    do_reset();
    wr(3, 32'h01);
    wr(2, 32'h01);
    pio = 8'h01;
    ticks(7);
    rd(1, d);
    n_cmp++;
    if (d !== 32'h1 || irq !== 1'b1) begin
      n_bad++;
      $display("FAIL rise_irq edge %h irq %b want 01/1", d, irq);
    end
    wr(1, 32'h01);
    rd(1, d);
    n_cmp++;
    if (d !== 32'h0 || irq !== 1'b0) begin
      n_bad++;
      $display("FAIL rise_clear edge %h irq %b want 0/0", d, irq);
    end
  endtask

  task automatic test_fall_mask();
    logic [31:0] d;
    do_reset();
    wr(4, 32'h80);
    pio = 8'h80;
    ticks(7);
    pio = 8'h00;
    ticks(7);
    rd(1, d);
    n_cmp++;
    if (d !== 32'h80 || irq !== 1'b0) begin
      n_bad++;
      $display("FAIL fall_edge edge %h irq %b want 80/0", d, irq);
    end
    wr(2, 32'h80);
    n_cmp++;
    if (irq !== 1'b1) begin
      n_bad++;
      $display("FAIL fall_mask irq %b want 1", irq);
    end
    wr(4, 32'h00);
    rd(1, d);
    n_cmp++;
    if (d !== 32'h80) begin
      n_bad++;
      $display("FAIL en_change edge %h want 80", d);
    end
    wr(2, 32'h00);
    rd(1, d);
    n_cmp++;
    if (irq !== 1'b0 || d !== 32'h80) begin
      n_bad++;
      $display("FAIL mask_off irq %b edge %h want 0/80", irq, d);
    end
  endtask

  task automatic test_set_wins();
    logic [31:0] d;
    do_reset();
    wr(3, 32'h02);
    ticks(2);
    pio = 8'h02;
    ticks(5);
    wr(1, 32'h02);
    rd(1, d);
    n_cmp++;
    if (d !== 32'h02) begin
      n_bad++;
      $display("FAIL set_wins edge %h want 02", d);
    end
  endtask

  task automatic test_random();
    logic [31:0] d, exp;
    int w;
    do_reset();
    pio = '0;
    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(0, 4) == 0)
        pio = pio ^ W'($urandom_range(1, 255));
      if ($urandom_range(0, 3) == 0)
        wr($urandom_range(0, 7), $urandom);
      else
        tick();
      for (int r = 0; r < 6; r++) begin
        w = (r < 5) ? r : $urandom_range(0, 63);
        rd(w, d);
        exp = exp_word(w);
        n_cmp++;
        if (d !== exp) begin
          n_bad++;
          $display("FAIL random c%0d w%0d got %h want %h", c, w, d, exp);
        end
      end
      n_cmp++;
      if (irq !== |(m_edge & m_mask)) begin
        n_bad++;
        $display("FAIL random_irq c%0d got %b want %b", c, irq,
                 |(m_edge & m_mask));
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] d, exp;
    do_reset();
    wr(3, 32'hFF);
    wr(4, 32'hFF);
    pio = 8'hFF;
    ticks(7);
    pio = 8'h00;
    ticks(7);
    rd(1, d);
    n_cmp++;
    if (d !== 32'hFF) begin
      n_bad++;
      $display("FAIL mid_pre edge %h want ff", d);
    end
    wr(2, 32'hFF);
    pio = 8'h01;
    ticks(2);
    #2;
    reset = 1'b1;
    model_reset();
    #1;
    n_cmp++;
    if (irq !== 1'b0) begin
      n_bad++;
      $display("FAIL mid_irq got %b want 0", irq);
    end
    for (int w = 0; w < 6; w++) begin
      addr = 8'(w * 4);
      #0.2;
      n_cmp++;
      if (dataout !== 32'h0) begin
        n_bad++;
        $display("FAIL mid_read a%h got %h want 0", addr, dataout);
      end
    end
    ticks(2);
    reset = 1'b0;
    for (int e = 0; e <= 6; e++) begin
      if (e == 0) wr(3, 32'h01);
      else tick();
      rd(0, d);
      exp = (e >= 5) ? 32'h1 : 32'h0;
      n_cmp++;
      if (d !== exp) begin
        n_bad++;
        $display("FAIL post_reset k+%0d got %h want %h", e, d, exp);
      end
    end
    rd(1, d);
    n_cmp++;
    if (d !== 32'h1) begin
      n_bad++;
      $display("FAIL post_reset_edge got %h want 1", d);
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_glitch();
    test_debounce();
    test_rise_irq();
    test_fall_mask();
    test_set_wins();
    test_random();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
